// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default operand width and the flag-sanity helper
// used by both the controller and its testbench checker.
package sar_pkg;

    localparam int SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_t;

    // True when exactly one of the comparator flags is asserted.
    function automatic logic flags_onehot(input logic less,
                                          input logic greater,
                                          input logic equal);
        return ({less, greater, equal} == 3'b100) ||
               ({less, greater, equal} == 3'b010) ||
               ({less, greater, equal} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation controller. Drives a probe value into an external
// combinational magnitude comparator and binary-searches its hidden operand,
// one bit per cycle from the MSB down.
// Optional feature macro: SAR_EARLY_EXIT_EN -- when defined, an equal flag
// ends the search at once with result = trial; otherwise equal counts as
// greater and every search runs the full WIDTH probes.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_less,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    output logic [WIDTH-1:0] trial,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = ONE << (WIDTH - 1);

    sar_state_t       state, next_state;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] idx;

    logic             flags_ok;
    logic             keep_bit;
    logic             eq_exit;
    logic             last_bit;
    logic             load;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] acc_upd;

    // Decode this probe's outcome from the comparator flags
    always_comb begin
        flags_ok = flags_onehot(cmp_less, cmp_greater, cmp_equal);
        keep_bit = cmp_greater | cmp_equal;
        bit_mask = ONE << idx;
        acc_upd  = keep_bit ? (acc | bit_mask) : acc;
        last_bit = (idx == '0);
        load     = start && (state != ST_PROBE);
`ifdef SAR_EARLY_EXIT_EN
        eq_exit  = cmp_equal;
`else
        eq_exit  = 1'b0;
`endif
    end

    // Next-state logic: a probe ends on a bad flag set, an early match or the LSB
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_PROBE;
            ST_PROBE: if (!flags_ok || eq_exit || last_bit) next_state = ST_DONE;
            ST_DONE:  if (start) next_state = ST_PROBE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Accumulator, bit index, probe value and captured result/error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            idx   <= TOP_IDX;
            trial <= MSB_MASK;
            err   <= 1'b0;
        end else if (state == ST_PROBE) begin
            if (!flags_ok) begin
                err    <= 1'b1;
                result <= acc;
            end else if (eq_exit) begin
                result <= trial;
            end else if (last_bit) begin
                acc    <= acc_upd;
                result <= acc_upd;
            end else begin
                acc   <= acc_upd;
                idx   <= idx - IDX_W'(1);
                trial <= acc_upd | (bit_mask >> 1);
            end
        end
    end

    assign busy = (state == ST_PROBE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a combinational comparator model closes
// the loop around a hidden operand, with optional forced flag patterns.
// Honours SAR_EARLY_EXIT_EN the same way the design does.
module tb_sar_search;
    import sar_pkg::*;

    localparam int W = SAR_WIDTH;
`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cmp_less, cmp_greater, cmp_equal;
    logic [W-1:0] trial, result;
    logic         busy, done, err;

    int           hidden_a = 0;
    logic         force_en = 1'b0;
    logic [2:0]   force_val = 3'b000;

    int pass_count = 0;
    int check_count = 0;

    sar_search #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmp_less(cmp_less), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
        .trial(trial), .result(result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Comparator model: A against trial, unless the bench forces a flag set
    always_comb begin
        if (force_en) begin
            {cmp_less, cmp_greater, cmp_equal} = force_val;
        end else begin
            cmp_less    = (hidden_a <  int'(trial));
            cmp_greater = (hidden_a >  int'(trial));
            cmp_equal   = (hidden_a == int'(trial));
        end
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        check_count++;
        if (obs == exp) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Upper k-1 bits of a: everything already decided before probe k
    function automatic int prefixOf(input int a, input int k);
        return a & ~((1 << (W - k + 1)) - 1) & ((1 << W) - 1);
    endfunction

    function automatic int expTrial(input int a, input int k);
        return prefixOf(a, k) | (1 << (W - k));
    endfunction

    // Reference outcome of a whole search from the binary-search rules
    task automatic predict(input int a, input int fprobe, input logic [2:0] fval,
                           output int len, output int res, output int e);
        len = W; res = a; e = 0;
        for (int k = 1; k <= W; k++) begin
            if (k == fprobe && !flags_onehot(fval[2], fval[1], fval[0])) begin
                len = k; res = prefixOf(a, k); e = 1;
                return;
            end
            if (EARLY && expTrial(a, k) == a) begin
                len = k; res = a;
                return;
            end
        end
    endtask

    // One complete search from start to done, checked cycle by cycle
    task automatic applyStimulus(input int a, input int fprobe,
                                 input logic [2:0] fval, input bit mid_start);
        int exp_len, exp_res, exp_err, k;
        predict(a, fprobe, fval, exp_len, exp_res, exp_err);
        hidden_a = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k <= W + 1) begin
            if (done) break;
            if (k == 1) checkOutput("done_drop", int'(done), 0);
            checkOutput("busy", int'(busy), 1);
            checkOutput($sformatf("trial_a%0d_p%0d", a, k), int'(trial), expTrial(a, k));
            if (k == fprobe) begin
                force_en = 1'b1;
                force_val = fval;
            end
            if (mid_start && k == 2) start = 1'b1;
            @(negedge clk);
            force_en = 1'b0;
            start = 1'b0;
            k++;
        end
        checkOutput("done", int'(done), 1);
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput($sformatf("latency_a%0d", a), k - 1, exp_len);
        checkOutput($sformatf("result_a%0d", a), int'(result), exp_res);
        checkOutput("err", int'(err), exp_err);
        repeat (2) @(negedge clk);
        checkOutput("done_hold", int'(done), 1);
        checkOutput("result_hold", int'(result), exp_res);
        checkOutput("err_hold", int'(err), exp_err);
    endtask

    initial begin
        logic [2:0] bad_flags [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        repeat (2) @(negedge clk);
        checkOutput("rst_trial", int'(trial), 0);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", int'(busy), 0);

        applyStimulus(9, 0, 3'b000, 1'b0);
        applyStimulus(8, 0, 3'b000, 1'b0);
        applyStimulus(0, 0, 3'b000, 1'b0);
        applyStimulus(15, 0, 3'b000, 1'b0);
        applyStimulus(12, 2, 3'b000, 1'b0);
        applyStimulus(9, 2, 3'b011, 1'b0);
        applyStimulus(5, 0, 3'b000, 1'b1);
        applyStimulus(11, 0, 3'b000, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int a, fp;
            a = int'($urandom_range((1 << W) - 1, 0));
            fp = ($urandom_range(3, 0) == 0) ? int'($urandom_range(W, 1)) : 0;
            applyStimulus(a, fp, bad_flags[$urandom_range(4, 0)], 1'($urandom_range(1, 0)));
        end

        // Asynchronous reset in the middle of probe 3
        hidden_a = 13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_trial", int'(trial), 0);
        checkOutput("arst_result", int'(result), 0);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_done", int'(done), 0);
        checkOutput("arst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_busy", int'(busy), 0);
        checkOutput("post_rst_done", int'(done), 0);
        checkOutput("post_rst_trial", int'(trial), 0);
        applyStimulus(6, 0, 3'b000, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
